// File: rtl/laser_pkg.sv
// Shared types and geometry helper for the LASER point-stream interface.
// Imported by the host, its point memory and any LASER-side models.
package laser_pkg;
    localparam int COORD_W      = 4;
    localparam int LASER_NUM_PT = 40;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_SEND,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } state_t;

    // True when p lies on or inside the circle of squared radius r2 centred at c.
    function automatic logic in_circle(input cord_t c, input cord_t p, input logic [8:0] r2);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic signed [7:0] dxe;
        logic signed [7:0] dye;
        logic [7:0]        sx;
        logic [7:0]        sy;
        logic [8:0]        sum;
        dx  = $signed({1'b0, c.x}) - $signed({1'b0, p.x});
        dy  = $signed({1'b0, c.y}) - $signed({1'b0, p.y});
        dxe = 8'(dx);
        dye = 8'(dy);
        sx  = dxe * dxe;
        sy  = dye * dye;
        sum = {1'b0, sx} + {1'b0, sy};
        return sum <= r2;
    endfunction
endpackage

// File: rtl/laser_pt_mem.sv
// Point memory for the LASER host: one synchronous write port, one
// combinational read port, entry index = img*NUM_PT + pt.
module laser_pt_mem
    import laser_pkg::*;
#(
    parameter int DEPTH = 240,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cord_t         wdata,
    input  logic [AW-1:0] raddr,
    output cord_t         rdata
);
    cord_t mem [DEPTH];

    // NOTE: the array has no reset; host-loaded points must survive rst_n and need no reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/laser_host.sv
// Host/driver for the LASER core: restarts it per image, streams the points,
// captures the two circle centres and scores how many points they cover.
module laser_host
    import laser_pkg::*;
#(
    parameter int NUM_IMG = 6,
    parameter int NUM_PT  = LASER_NUM_PT,
    parameter int RADIUS2 = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [$clog2(NUM_IMG*NUM_PT)-1:0] wr_addr,
    input  logic [7:0]                        wr_data,
    input  logic                              start,
    output logic                              busy,
    output logic                              l_rst,
    output logic [3:0]                        l_x,
    output logic [3:0]                        l_y,
    input  logic [3:0]                        l_c1x,
    input  logic [3:0]                        l_c1y,
    input  logic [3:0]                        l_c2x,
    input  logic [3:0]                        l_c2y,
    input  logic                              l_done,
    output logic                              res_valid,
    output logic [$clog2(NUM_IMG)-1:0]        res_img,
    output logic [7:0]                        res_c1,
    output logic [7:0]                        res_c2,
    output logic [5:0]                        res_cover,
    output logic                              res_to,
    output logic                              all_done
);
    localparam int         DEPTH = NUM_IMG * NUM_PT;
    localparam int         AW    = $clog2(DEPTH);
    localparam int         IW    = $clog2(NUM_IMG);
    localparam int         PW    = $clog2(NUM_PT);
    localparam int         TW    = $clog2(TIMEOUT);
    localparam logic [8:0] R2    = 9'(RADIUS2);

    state_t        state_q, state_d;
    logic [IW-1:0] img_q, img_d;
    logic [AW-1:0] base_q, base_d;
    logic [PW-1:0] pt_q, pt_d;
    logic [TW-1:0] to_q, to_d;
    cord_t         c1_q, c1_d;
    cord_t         c2_q, c2_d;
    logic [5:0]    cover_q, cover_d;

    logic          busy_q, busy_d;
    logic          l_rst_q, l_rst_d;
    cord_t         l_xy_q, l_xy_d;
    logic          res_valid_q, res_valid_d;
    logic [IW-1:0] res_img_q, res_img_d;
    cord_t         res_c1_q, res_c1_d;
    cord_t         res_c2_q, res_c2_d;
    logic [5:0]    res_cover_q, res_cover_d;
    logic          res_to_q, res_to_d;
    logic          all_done_q, all_done_d;

    logic          idle_ready;
    logic          mem_we;
    logic [PW-1:0] rd_pt;
    logic [AW-1:0] rd_addr;
    cord_t         rd_data;
    logic          covered;

    // Host writes and START are only honoured once the ALL_DONE cycle has passed.
    assign idle_ready = (state_q == ST_IDLE) && !busy_q;
    assign mem_we     = wr_en && idle_ready && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));

    // SEND presents the next point so it is registered onto l_x/l_y in time.
    always_comb begin
        rd_pt = '0;
        if (state_q == ST_SEND && pt_q != PW'(NUM_PT - 1)) begin
            rd_pt = pt_q + PW'(1);
        end else if (state_q == ST_SCORE) begin
            rd_pt = pt_q;
        end
    end

    assign rd_addr = base_q + AW'(rd_pt);
    assign covered = in_circle(c1_q, rd_data, R2) || in_circle(c2_q, rd_data, R2);

    laser_pt_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        base_d      = base_q;
        pt_d        = pt_q;
        to_d        = to_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        cover_d     = cover_q;
        l_xy_d      = '0;
        res_valid_d = 1'b0;
        res_img_d   = res_img_q;
        res_c1_d    = res_c1_q;
        res_c2_d    = res_c2_q;
        res_cover_d = res_cover_q;
        res_to_d    = res_to_q;
        all_done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (idle_ready && start) begin
                    state_d = ST_KICK;
                    img_d   = '0;
                    base_d  = '0;
                end
            end
            ST_KICK: begin
                state_d = ST_SEND;
                pt_d    = '0;
                l_xy_d  = rd_data;
            end
            ST_SEND: begin
                if (pt_q == PW'(NUM_PT - 1)) begin
                    state_d = ST_WAIT;
                    to_d    = '0;
                end else begin
                    pt_d   = pt_q + PW'(1);
                    l_xy_d = rd_data;
                end
            end
            ST_WAIT: begin
                if (l_done) begin
                    state_d = ST_SCORE;
                    c1_d    = {l_c1x, l_c1y};
                    c2_d    = {l_c2x, l_c2y};
                    pt_d    = '0;
                    cover_d = '0;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    state_d     = ST_REPORT;
                    res_valid_d = 1'b1;
                    res_img_d   = img_q;
                    res_c1_d    = '0;
                    res_c2_d    = '0;
                    res_cover_d = '0;
                    res_to_d    = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_SCORE: begin
                cover_d = cover_q + 6'(covered);
                if (pt_q == PW'(NUM_PT - 1)) begin
                    state_d     = ST_REPORT;
                    res_valid_d = 1'b1;
                    res_img_d   = img_q;
                    res_c1_d    = c1_q;
                    res_c2_d    = c2_q;
                    res_cover_d = cover_d;
                    res_to_d    = 1'b0;
                end else begin
                    pt_d = pt_q + PW'(1);
                end
            end
            ST_REPORT: begin
                if (img_q == IW'(NUM_IMG - 1)) begin
                    state_d    = ST_IDLE;
                    all_done_d = 1'b1;
                end else begin
                    state_d = ST_KICK;
                    img_d   = img_q + IW'(1);
                    base_d  = base_q + AW'(NUM_PT);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE) || all_done_d;
        l_rst_d = (state_d == ST_IDLE) || (state_d == ST_KICK);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            img_q       <= '0;
            base_q      <= '0;
            pt_q        <= '0;
            to_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            cover_q     <= '0;
            busy_q      <= 1'b0;
            l_rst_q     <= 1'b1;
            l_xy_q      <= '0;
            res_valid_q <= 1'b0;
            res_img_q   <= '0;
            res_c1_q    <= '0;
            res_c2_q    <= '0;
            res_cover_q <= '0;
            res_to_q    <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            base_q      <= base_d;
            pt_q        <= pt_d;
            to_q        <= to_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            cover_q     <= cover_d;
            busy_q      <= busy_d;
            l_rst_q     <= l_rst_d;
            l_xy_q      <= l_xy_d;
            res_valid_q <= res_valid_d;
            res_img_q   <= res_img_d;
            res_c1_q    <= res_c1_d;
            res_c2_q    <= res_c2_d;
            res_cover_q <= res_cover_d;
            res_to_q    <= res_to_d;
            all_done_q  <= all_done_d;
        end
    end

    assign busy      = busy_q;
    assign l_rst     = l_rst_q;
    assign l_x       = l_xy_q.x;
    assign l_y       = l_xy_q.y;
    assign res_valid = res_valid_q;
    assign res_img   = res_img_q;
    assign res_c1    = res_c1_q;
    assign res_c2    = res_c2_q;
    assign res_cover = res_cover_q;
    assign res_to    = res_to_q;
    assign all_done  = all_done_q;
endmodule
